// File: rtl/apb_rr_pkg.sv
// Shared types and constants for the round-robin APB master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the top: APB_PREADY_EN.
package apb_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int WAIT_W      = 8;

    // Width of a grant index for n requesters (never below 1 bit).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Combinational round-robin pick: first valid at or above ptr, wrapping to 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when the pick is an accept.
// Ports: valid (request vector), ptr (search start), gnt (one-hot),
//        idx (binary index of gnt), any (some request is valid).
module apb_rr_arb
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Upper segment first (ptr..NUM_REQ-1), then the wrapped lower segment.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any && valid[j] && (j >= int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any && valid[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB bus among NUM_REQ requesters.
// Latency: accept to rsp_valid = 3 cycles (+ pready wait cycles); 2 cycles/transfer saturated.
// Backpressure: req_ready only at IDLE or the completing ACCESS cycle; pready stalls ACCESS.
// Ports: clk/rst (async active-high), req_* flat request buses, req_ready one-hot accept,
//        rsp_valid/rsp_rdata completion, paddr/pwrite/psel/penable/pwdata/prdata APB bus.
// APB_PREADY_EN adds pready (in) and wait_cnt (out, saturating wait-cycle count).
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef APB_PREADY_EN
    input  logic                      pready,
    output logic [WAIT_W-1:0]         wait_cnt,
`endif
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IW = idx_w(NUM_REQ);

    apb_state_e         state, state_nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gidx;
    logic [NUM_REQ-1:0] gidx_oh;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               access_done;
    logic               arb_pt;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;

    apb_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef APB_PREADY_EN
    assign access_done = (state == ACCESS) && pready;
`else
    assign access_done = (state == ACCESS);
`endif

    // A new grant is only possible when the bus is free or about to be.
    assign arb_pt    = (state == IDLE) || access_done;
    assign accept    = arb_pt && arb_any;
    assign req_ready = arb_pt ? arb_gnt : '0;

    // Winner's request fields, selected by the one-hot grant.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_gnt[j]) begin
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[j*DATA_W +: DATA_W];
                sel_write = req_write[j];
            end
        end
    end

    always_comb begin
        gidx_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gidx_oh[j] = (gidx == IW'(j));
        end
    end

    // Next state and APB strobes; psel/penable decode from state so an
    // asynchronous reset drops them immediately.
    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (access_done) state_nxt = accept ? SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            gidx      <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (access_done) begin
                rsp_valid <= gidx_oh;
                rsp_rdata <= pwrite ? '0 : prdata;
            end
            if (accept) begin
                paddr  <= sel_addr;
                pwrite <= sel_write;
                pwdata <= sel_wdata;
                gidx   <= arb_idx;
                ptr    <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

`ifdef APB_PREADY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_nxt == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready && (wait_cnt != {WAIT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: transfer-level model compared every cycle
// plus directed vectors with literal expectations.
module tb_apb_rr_master;
    import apb_rr_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic            psel;
    logic            penable;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata = '0;
`ifdef APB_PREADY_EN
    logic            pready = 1'b1;
    logic [7:0]      wait_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apb_rr_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef APB_PREADY_EN
        .pready    (pready),
        .wait_cnt  (wait_cnt),
`endif
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit pready_now();
`ifdef APB_PREADY_EN
        return pready;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- transfer-level model ----------------
    // A transfer accepted in cycle t_acc shows SETUP at t_acc+1, ACCESS from
    // t_acc+2 until pready, and its response the cycle after completion.
    int            m_ptr, m_cur, t_acc, cyc;
    bit            act;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  e_rsp;
    logic [DW-1:0] e_rdata;

    always @(negedge clk) begin : model
        bit           e_psel, e_pen, done, arb;
        int           g;
        logic [N-1:0] e_rdy;
        if (rst) begin
            m_ptr = 0; m_cur = 0; t_acc = 0; cyc = 0; act = 0;
            m_addr = '0; m_write = 1'b0; m_wdata = '0;
            e_rsp = '0; e_rdata = '0;
        end else begin
            e_psel = act && (cyc > t_acc);
            e_pen  = act && (cyc >= t_acc + 2);
            done   = e_pen && pready_now();
            arb    = !act || done;
            g      = -1;
            e_rdy  = '0;
            if (arb) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            if (g >= 0) e_rdy[g] = 1'b1;
            chk("m_req_ready", req_ready, e_rdy);
            chk("m_psel", psel, e_psel);
            chk("m_penable", penable, e_pen);
            chk("m_rsp_valid", rsp_valid, e_rsp);
            chk("m_rsp_rdata", rsp_rdata, e_rdata);
            chk("m_paddr", paddr, m_addr);
            chk("m_pwrite", pwrite, m_write);
            chk("m_pwdata", pwdata, m_wdata);
`ifdef APB_PREADY_EN
            if (e_pen) chk("m_wait_cnt", wait_cnt,
                           (cyc - t_acc - 2 > 255) ? 255 : cyc - t_acc - 2);
`endif
            e_rsp = '0;
            if (done) begin
                e_rsp[m_cur] = 1'b1;
                e_rdata      = m_write ? '0 : prdata;
                act          = 0;
            end
            if (g >= 0) begin
                act     = 1;
                m_cur   = g;
                t_acc   = cyc;
                m_addr  = req_addr[g*AW +: AW];
                m_write = req_write[g];
                m_wdata = req_wdata[g*DW +: DW];
                m_ptr   = (g + 1) % N;
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    // One isolated transfer: accept checked literally, then run to idle.
    task automatic xfer(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [N-1:0] exp_rdy);
        step();
        set_req(i, wr, a, d);
        #1 chk("x_rdy", req_ready, exp_rdy);
        step();
        req_valid[i] = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pwdata", pwdata, 0);
        rst = 1'b0;

        // Single write from requester 0.
        step();
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        #1 chk("t1_rdy", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        #1 chk("t1_c1_psel", psel, 1);
        chk("t1_c1_penable", penable, 0);
        chk("t1_c1_paddr", paddr, 8'h10);
        step();
        #1 chk("t1_c2_penable", penable, 1);
        chk("t1_c2_pwdata", pwdata, 32'hDEADBEEF);
        chk("t1_c2_pwrite", pwrite, 1);
        step();
        #1 chk("t1_c3_psel", psel, 0);
        chk("t1_c3_penable", penable, 0);
        chk("t1_c3_rsp", rsp_valid, 4'b0001);

        // Read from requester 2.
        step();
        set_req(2, 1'b0, 8'h24, 32'h0);
        prdata = 32'hCAFE0001;
        #1 chk("t2_rdy", req_ready, 4'b0100);
        step();
        req_valid[2] = 1'b0;
        step();
        #1 chk("t2_paddr", paddr, 8'h24);
        step();
        #1 chk("t2_rsp", rsp_valid, 4'b0100);
        chk("t2_rdata", rsp_rdata, 32'hCAFE0001);

        // Saturation from a fresh reset: grants 0,1,2,3,0, psel held high.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(8'h40 + i), DW'(i));
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            #1 chk("t3_rdy", req_ready, (c % 2 == 0) ? (64'd1 << ((c / 2) % 4)) : 64'd0);
            chk("t3_psel", psel, (c >= 1) ? 1 : 0);
        end
        step();
        req_valid = '0;
        #1 chk("t3_c10_penable", penable, 1);
        step();
        #1 chk("t3_c11_psel", psel, 0);
        chk("t3_c11_rsp", rsp_valid, 4'b0001);

        // Move pointer to 2, then a lone req 1 must still win and leave it at 2.
        xfer(1, 1'b1, 8'h51, 32'h11, 4'b0010);
        xfer(1, 1'b1, 8'h52, 32'h22, 4'b0010);
        step();
        set_req(1, 1'b1, 8'h53, 32'h33);
        set_req(2, 1'b1, 8'h63, 32'h44);
        #1 chk("t4_rdy_ptr2", req_ready, 4'b0100);
        step();
        req_valid[2] = 1'b0;
        step();
        #1 chk("t4_rdy_wrap", req_ready, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        step();
        step();

        // Reset during ACCESS drops the transfer; pending req 3 wins afterwards.
        step();
        set_req(0, 1'b1, 8'h70, 32'h77);
        step();
        req_valid[0] = 1'b0;
        step();
        #1 chk("t5_in_access", penable, 1);
        rst = 1'b1;
        set_req(3, 1'b0, 8'h33, 32'h0);
        #1 chk("t5_rst_psel", psel, 0);
        chk("t5_rst_penable", penable, 0);
        chk("t5_rst_rsp", rsp_valid, 0);
        step();
        rst = 1'b0;
        #1 chk("t5_rdy", req_ready, 4'b1000);
        step();
        req_valid[3] = 1'b0;
        step();
        step();
        #1 chk("t5_rsp", rsp_valid, 4'b1000);
        chk("t5_rdata", rsp_rdata, 32'hCAFE0001);

`ifdef APB_PREADY_EN
        // Three wait cycles: ACCESS spans 4 cycles, no accept while waiting.
        step();
        set_req(0, 1'b1, 8'h55, 32'h12345678);
        set_req(1, 1'b1, 8'h66, 32'h9);
        #1 chk("t6_rdy", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        pready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            step();
            #1 chk("t6_wait_rdy", req_ready, 0);
            chk("t6_wait_penable", penable, 1);
            chk("t6_wait_paddr", paddr, 8'h55);
            chk("t6_wait_cnt", wait_cnt, w);
        end
        step();
        pready = 1'b1;
        #1 chk("t6_wait_cnt_final", wait_cnt, 3);
        chk("t6_done_rdy", req_ready, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        step();
        step();
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master: shares one APB bus (paddr/pwrite/psel/penable/pwdata/prdata) among NUM_REQ internal requesters.
- Accepts one request per transfer, sequences the APB SETUP/ACCESS phases and returns read data to the winning requester.
- Sits between on-chip initiators (config engines, debug port) and the APB slave fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  flat addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flat write data, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data for the requester flagged by rsp_valid.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; round-robin pointer = 0.
- Reset asserted mid-transfer: psel/penable drop immediately, the in-flight transfer is dropped, and no rsp_valid is issued for it.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration point: IDLE, or the final ACCESS cycle.
- At the arbitration point, the arbiter picks the first asserted req_valid searching upward (mod NUM_REQ) from the pointer.
- req_ready[g] is combinational and asserts only in that cycle, only if req_valid[g] = 1. That cycle is the accept.
- On accept:
  - Register req_addr/req_write/req_wdata of the winner into paddr/pwrite/pwdata.
  - Register the grant index.
  - pointer <= g+1 (wrap at NUM_REQ).
  - Next state = SETUP.
- SETUP: psel=1, penable=0. Always exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Completes in 1 cycle.
- At ACCESS completion:
  - Sample prdata if it is a read (0 if it is a write).
  - Next cycle: rsp_valid[grant]=1 and rsp_rdata = sampled value.
  - If a request is accepted in the same cycle, go to SETUP (back-to-back, psel stays 1). Otherwise go to IDLE with psel=0, penable=0.
- Throughput: 2 cycles per transfer when saturated.
- Latency: accept to rsp_valid = 3 cycles.
- paddr/pwrite/pwdata hold stable from SETUP through ACCESS. They keep their last value in IDLE.
- Requesters hold valid and fields stable until req_ready. A requester may deassert valid before being granted.
- rsp_rdata holds its value until the next rsp_valid.
- No valid requests: stay IDLE, pointer unchanged.
- Single active requester: granted every arbitration point; the pointer still advances past it.

Optional Feature:
- Macro APB_PREADY_EN.
- With it defined:
  - Adds input port pready (1 bit).
  - ACCESS completes only in a cycle with pready=1. While pready=0, stay in ACCESS with all APB outputs stable and no arbitration.
  - Adds output wait_cnt (8 bits): counts wait cycles of the current transfer, saturates at 255, clears on SETUP entry.
- Without it: no pready or wait_cnt ports; ACCESS is always exactly 1 cycle.

Decomposition:
- Package apb_rr_pkg:
  - State enum apb_state_e {IDLE, SETUP, ACCESS}.
  - Default width constants.
  - Function idx_w(n) = $clog2 for the grant-index width.
- Sub-module apb_rr_arb: combinational round-robin pick, producing the one-hot grant and index from valid and pointer. The pointer register lives in the parent.

Test Plan:
- Single write, req 0 (addr 0x10, wdata 0xDEADBEEF):
  - req_ready[0] in cycle 0.
  - psel=1/penable=0 in cycle 1, penable=1 in cycle 2, both 0 in cycle 3.
  - rsp_valid[0] in cycle 3.
- Read, req 2 (addr 0x24), slave returns prdata 0xCAFE0001 in ACCESS -> rsp_valid[2]=1 with rsp_rdata 0xCAFE0001 one cycle after ACCESS.
- All four requesters valid continuously -> grant order 0,1,2,3,0; psel held high; exactly one rsp_valid every 2 cycles.
- Pointer at 2, only req 1 valid -> req 1 granted; pointer becomes 2.
- Reset asserted during ACCESS -> psel/penable/rsp_valid immediately 0; after release, req 3 pending is granted first (pointer = 0 search finds 3).
- With APB_PREADY_EN, pready low for 3 cycles -> ACCESS lasts 4 cycles, wait_cnt reaches 3, APB outputs stable, no req_ready during waits.
